// File: rtl/pipe_elastic_chain.sv
// Parametrised elastic pipeline-register chain with valid/ready flow, per-stage stalls,
// partial flush and occupancy / stall statistics. Stage 0 is youngest, STAGES-1 oldest.
module pipe_elastic_chain #(
    parameter int  STAGES = 4,
    parameter int  WIDTH  = 32,
    parameter int  CNT_W  = 32,
    localparam int IDX_W  = $clog2(STAGES),
    localparam int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    input  logic [STAGES-1:0]        stall_req,
    input  logic                     flush_req,
    input  logic [IDX_W-1:0]         flush_stage,
    output logic [STAGES-1:0]        stage_valid,
    output logic [STAGES*WIDTH-1:0]  stage_data,
    output logic [OCC_W-1:0]         occupancy,
    output logic [CNT_W-1:0]         stall_cycles
);

    logic [STAGES-1:0] v_r;
    logic [WIDTH-1:0]  d_r [STAGES];
    logic [OCC_W-1:0]  occ_r;
    logic [CNT_W-1:0]  stall_cnt_r;

    logic [STAGES-1:0] leave_s;
    logic [STAGES-1:0] accept_s;
    logic [STAGES-1:0] kill_s;
    logic [IDX_W-1:0]  flush_lim_s;
    logic [STAGES-1:0] v_nxt_s;
    logic [WIDTH-1:0]  d_nxt_s [STAGES];
    logic              stall_hit_s;

    function automatic logic [OCC_W-1:0] popcount(input logic [STAGES-1:0] vec);
        logic [OCC_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            cnt = cnt + OCC_W'(vec[i]);
        end
        return cnt;
    endfunction

    // Ready ripples from the output back to stage 0 so an empty stage always accepts.
    always_comb begin
        logic down_acc;
        down_acc = out_ready;
        leave_s  = '0;
        accept_s = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            leave_s[i]  = v_r[i] & ~stall_req[i] & down_acc;
            accept_s[i] = ~v_r[i] | leave_s[i];
            down_acc    = accept_s[i];
        end
    end

    // Clamp the flush index so out-of-range values kill the whole chain.
    always_comb begin
        if (int'(flush_stage) >= STAGES - 1) begin
            flush_lim_s = IDX_W'(STAGES - 1);
        end else begin
            flush_lim_s = flush_stage;
        end
    end

    // Stages at or younger than the flush limit are killed.
    always_comb begin
        kill_s = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (flush_req && (i <= int'(flush_lim_s))) begin
                kill_s[i] = 1'b1;
            end else begin
                kill_s[i] = 1'b0;
            end
        end
    end

    assign stall_hit_s = |(stall_req & v_r);
    // A flush swallows the incoming beat, so the input side is always ready then.
    assign in_ready    = flush_req | accept_s[0];

    // Next-state valid and payload; payload is only written on a valid load.
    always_comb begin
        logic src_v;
        v_nxt_s = v_r;
        d_nxt_s = d_r;
        src_v   = 1'b0;
        if (kill_s[0]) begin
            v_nxt_s[0] = 1'b0;
        end else if (accept_s[0]) begin
            v_nxt_s[0] = in_valid;
            if (in_valid) begin
                d_nxt_s[0] = in_data;
            end else begin
                d_nxt_s[0] = d_r[0];
            end
        end else begin
            v_nxt_s[0] = v_r[0];
        end
        for (int i = 1; i < STAGES; i++) begin
            src_v = v_r[i-1] & leave_s[i-1] & ~kill_s[i-1];
            if (kill_s[i]) begin
                v_nxt_s[i] = 1'b0;
            end else if (accept_s[i]) begin
                v_nxt_s[i] = src_v;
                if (src_v) begin
                    d_nxt_s[i] = d_r[i-1];
                end else begin
                    d_nxt_s[i] = d_r[i];
                end
            end else begin
                v_nxt_s[i] = v_r[i];
            end
        end
    end

    // Stage registers and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_r         <= '0;
            occ_r       <= '0;
            stall_cnt_r <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d_r[i] <= '0;
            end
        end else begin
            v_r   <= v_nxt_s;
            occ_r <= popcount(v_nxt_s);
            for (int i = 0; i < STAGES; i++) begin
                d_r[i] <= d_nxt_s[i];
            end
            if (stall_hit_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    // Flatten per-stage payload registers onto the observation bus.
    always_comb begin
        stage_data = '0;
        for (int i = 0; i < STAGES; i++) begin
            stage_data[i*WIDTH +: WIDTH] = d_r[i];
        end
    end

    assign out_valid    = v_r[STAGES-1];
    assign out_data     = d_r[STAGES-1];
    assign stage_valid  = v_r;
    assign occupancy    = occ_r;
    assign stall_cycles = stall_cnt_r;

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// Directed self-checking bench for pipe_elastic_chain (STAGES=4): streaming, backpressure,
// bubble compression under stall, partial and full flush, asynchronous reset mid-stream.
module tb_pipe_elastic_chain;

    localparam int STAGES = 4;
    localparam int WIDTH  = 32;
    localparam int CNT_W  = 32;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        in_data;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic [STAGES-1:0]       stall_req;
    logic                    flush_req;
    logic [1:0]              flush_stage;
    logic [STAGES-1:0]       stage_valid;
    logic [STAGES*WIDTH-1:0] stage_data;
    logic [2:0]              occupancy;
    logic [CNT_W-1:0]        stall_cycles;

    int test_cnt = 0;
    int fail_cnt = 0;

    pipe_elastic_chain #(.STAGES(STAGES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .stall_req(stall_req), .flush_req(flush_req), .flush_stage(flush_stage),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .occupancy(occupancy), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        test_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt + 1);
        $fatal(1);
    end

    initial begin
        logic [WIDTH-1:0] got [3];
        logic [WIDTH-1:0] exp_stage [STAGES];
        int n;
        int beat;

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        stall_req = '0; flush_req = 1'b0; flush_stage = 2'd0;
        tick(); tick();
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_occupancy", 64'(occupancy), 64'd0);
        check_eq("rst_stall_cycles", 64'(stall_cycles), 64'd0);
        check_eq("rst_stage_valid", 64'(stage_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // 1: streaming with out_ready=1, four-edge latency, one beat per cycle
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'h11 * (c + 1));
            #1;
            check_eq("t1_in_ready", 64'(in_ready), 64'd1);
            tick();
            if (c >= 3) begin
                check_eq("t1_out_valid", 64'(out_valid), 64'd1);
                check_eq("t1_out_data", 64'(out_data), 64'(32'(32'h11 * (c - 2))));
            end
        end
        check_eq("t1_occupancy", 64'(occupancy), 64'd4);
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        check_eq("t1_drain_valid", 64'(out_valid), 64'd0);
        check_eq("t1_drain_occ", 64'(occupancy), 64'd0);

        // 2: backpressure fills the chain, then drains in order
        out_ready = 1'b0;
        beat = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'h11 * (beat + 1));
            #1;
            check_eq("t2_in_ready", 64'(in_ready), (c < 4) ? 64'd1 : 64'd0);
            if (in_ready) beat++;
            tick();
        end
        check_eq("t2_out_valid", 64'(out_valid), 64'd1);
        check_eq("t2_out_hold", 64'(out_data), 64'h11);
        check_eq("t2_occupancy", 64'(occupancy), 64'd4);
        check_eq("t2_stage_valid", 64'(stage_valid), 64'hf);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("t2_drain_valid", 64'(out_valid), 64'd1);
            check_eq("t2_drain_data", 64'(out_data), 64'(32'(32'h11 * (k + 1))));
            tick();
        end
        check_eq("t2_empty", 64'(out_valid), 64'd0);

        // 3: bubble at stage 2, stall oldest stage; younger stages compress into the bubble
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'hA0; tick();
        in_valid = 1'b0;                   tick();
        in_valid = 1'b1; in_data = 32'hB0; tick();
        in_valid = 1'b1; in_data = 32'hC0; tick();
        check_eq("t3_bubble", 64'(stage_valid), 64'hb);
        stall_req = 4'b1100;
        out_ready = 1'b1;
        in_data   = 32'hD0;
        #1;
        check_eq("t3_in_ready", 64'(in_ready), 64'd1);
        tick();
        stall_req = '0;
        check_eq("t3_stage_valid", 64'(stage_valid), 64'hf);
        check_eq("t3_stall_cycles", 64'(stall_cycles), 64'd1);
        exp_stage[3] = 32'hA0; exp_stage[2] = 32'hB0;
        exp_stage[1] = 32'hC0; exp_stage[0] = 32'hD0;
        for (int i = 0; i < STAGES; i++) begin
            check_eq($sformatf("t3_stage_data%0d", i), 64'(stage_data[i*WIDTH +: WIDTH]), 64'(exp_stage[i]));
        end

        // 4: flush stages 0..1 of a full chain while E is offered
        out_ready   = 1'b0;
        flush_req   = 1'b1;
        flush_stage = 2'd1;
        in_valid    = 1'b1;
        in_data     = 32'hE0;
        #1;
        check_eq("t4_in_ready", 64'(in_ready), 64'd1);
        tick();
        flush_req = 1'b0;
        check_eq("t4_stage_valid", 64'(stage_valid), 64'hc);
        check_eq("t4_occupancy", 64'(occupancy), 64'd2);
        check_eq("t4_out_data", 64'(out_data), 64'hA0);
        out_ready = 1'b1;
        in_data   = 32'hF0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (c == 0);
            #1;
            if (out_valid) begin
                if (n < 3) got[n] = out_data;
                n++;
            end
            tick();
        end
        check_eq("t4_out_count", 64'(n), 64'd3);
        check_eq("t4_seq0", 64'(got[0]), 64'hA0);
        check_eq("t4_seq1", 64'(got[1]), 64'hB0);
        check_eq("t4_seq2", 64'(got[2]), 64'hF0);

        // 5: flush at the oldest index overrides a stall and empties everything
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h71; tick();
        in_data = 32'h72; tick();
        check_eq("t5_pre_valid", 64'(stage_valid), 64'h3);
        flush_req   = 1'b1;
        flush_stage = 2'd3;
        stall_req   = 4'b0001;
        in_data     = 32'h73;
        #1;
        check_eq("t5_in_ready_flush", 64'(in_ready), 64'd1);
        tick();
        flush_req = 1'b0; stall_req = '0; in_valid = 1'b0;
        #1;
        check_eq("t5_stage_valid", 64'(stage_valid), 64'd0);
        check_eq("t5_occupancy", 64'(occupancy), 64'd0);
        check_eq("t5_out_valid", 64'(out_valid), 64'd0);
        check_eq("t5_in_ready", 64'(in_ready), 64'd1);
        check_eq("t5_stall_cycles", 64'(stall_cycles), 64'd2);

        // 6: asynchronous reset mid-stream under backpressure
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'h81 + c);
            tick();
        end
        check_eq("t6_pre_out_valid", 64'(out_valid), 64'd1);
        in_data = 32'h85;
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t6_out_valid", 64'(out_valid), 64'd0);
        check_eq("t6_stage_valid", 64'(stage_valid), 64'd0);
        check_eq("t6_occupancy", 64'(occupancy), 64'd0);
        check_eq("t6_stall_cycles", 64'(stall_cycles), 64'd0);
        check_eq("t6_out_data", 64'(out_data), 64'd0);
        check_eq("t6_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 32'(32'h31 + c);
            tick();
            if (c >= 3) begin
                check_eq("t6_resume_valid", 64'(out_valid), 64'd1);
                check_eq("t6_resume_data", 64'(out_data), 64'(32'(32'h31 + c - 3)));
            end
        end
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
